// File: rtl/instr_seq_unit.sv
// Instruction sequencer: streams a loaded program from BRAM port B to the
// PE array through a 3-entry prefetch FIFO, stopping on HALT or end of BRAM.
module instr_seq_unit #(
  parameter int         INSTR_BRAM_DEPTH = 11,
  parameter int         INSTR_WIDTH      = 32,
  parameter logic [3:0] HALT_OPCODE      = 4'hF
) (
  input  logic                        S_AXIS_ACLK,
  input  logic                        S_AXIS_ARESETN,
  input  logic                        VALID_FU2PE,
  output logic [INSTR_BRAM_DEPTH-1:0] instr_rd_addr,
  output logic                        instr_rd_en,
  input  logic [INSTR_WIDTH-1:0]      instr_rd_dout,
  output logic [INSTR_WIDTH-1:0]      pe_instr,
  output logic                        pe_instr_valid,
  input  logic                        pe_instr_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [INSTR_BRAM_DEPTH-1:0] LAST_ADDR = '1;

  state_t                      state;
  logic [INSTR_WIDTH-1:0]      buf_q [3];
  logic [1:0]                  rd_ptr;
  logic [1:0]                  wr_ptr;
  logic [1:0]                  count;
  logic                        inflight;
  logic                        inflight_last;
  logic                        addr_done;
  logic [INSTR_BRAM_DEPTH-1:0] rd_addr;

  logic       ret;
  logic       ret_halt;
  logic       push;
  logic       pop;
  logic [2:0] occ;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign ret      = inflight && (state == RUN);
  assign ret_halt = ret &&
    (instr_rd_dout[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
  assign push     = ret && !ret_halt;
  assign pop      = pe_instr_valid && pe_instr_ready;
  assign occ      = {1'b0, count} + {2'b0, inflight};

  // A returning HALT suppresses the read issued alongside it.
  assign instr_rd_en = (state == RUN) && (occ < 3'd3) &&
                       !addr_done && !ret_halt;

  assign instr_rd_addr  = rd_addr;
  assign pe_instr       = buf_q[rd_ptr];
  assign pe_instr_valid = (count != 2'd0);
  assign busy           = (state == RUN) || (state == DRAIN);
  assign done           = (state == DONE);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state         <= IDLE;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      addr_done     <= 1'b0;
      err_overrun   <= 1'b0;
      rd_ptr        <= 2'd0;
      wr_ptr        <= 2'd0;
      count         <= 2'd0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      inflight      <= instr_rd_en;
      inflight_last <= instr_rd_en && (rd_addr == LAST_ADDR);
      if (instr_rd_en) begin
        if (rd_addr == LAST_ADDR) addr_done <= 1'b1;
        else rd_addr <= rd_addr + 1'b1;
      end
      if (push) begin
        buf_q[wr_ptr] <= instr_rd_dout;
        wr_ptr        <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push && !pop) count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;

      unique case (state)
        IDLE: begin
          if (VALID_FU2PE) begin
            state       <= RUN;
            rd_addr     <= '0;
            addr_done   <= 1'b0;
            err_overrun <= 1'b0;
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
            count       <= 2'd0;
          end
        end
        RUN: begin
          if (ret_halt) begin
            state <= DRAIN;
          end else if (ret && inflight_last) begin
            err_overrun <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == 2'd0 && !inflight) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq_unit.sv
// Bench for instr_seq_unit: directed scenarios plus random programs,
// checked each cycle against a queue-based model of the sequencer.
module tb_instr_seq_unit;

  localparam int A = 3;
  localparam int W = 32;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vfu = 1'b0;
  logic         rdy = 1'b0;
  logic [A-1:0] addr;
  logic         rd_en;
  logic [W-1:0] dout = '0;
  logic [W-1:0] pe_instr;
  logic         pe_valid;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  instr_seq_unit #(.INSTR_BRAM_DEPTH(A)) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .VALID_FU2PE    (vfu),
    .instr_rd_addr  (addr),
    .instr_rd_en    (rd_en),
    .instr_rd_dout  (dout),
    .pe_instr       (pe_instr),
    .pe_instr_valid (pe_valid),
    .pe_instr_ready (rdy),
    .busy           (busy),
    .done           (done),
    .err_overrun    (err)
  );

  logic [W-1:0] mem [N];
  always @(posedge clk) if (rd_en) dout <= mem[addr];

  // reference model: words expected in the buffer, one pending read
  logic [W-1:0] q[$];
  bit           pend;
  int           pend_a;
  int           nxt_a;
  bit           last_iss;
  bit           m_run;
  bit           m_drain;
  bit           m_done;
  bit           m_err;
  bit           prev_stall;
  logic [W-1:0] prev_instr;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_done = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_halt(input logic [W-1:0] w);
    return w[W-1:W-4] == 4'hF;
  endfunction

  function automatic bit exp_rd();
    bit hret;
    hret = m_run && pend && is_halt(mem[pend_a]);
    return m_run && (q.size() + 32'(pend) < 3) && !last_iss && !hret;
  endfunction

  task automatic model_reset();
    q.delete();
    pend = 0; pend_a = 0; nxt_a = 0; last_iss = 0;
    m_run = 0; m_drain = 0; m_done = 0; m_err = 0;
    prev_stall = 0; prev_instr = '0;
  endtask

  function automatic bit rdy_fn(input int mode, input int k);
    bit [5:0] pat;
    pat = 6'b101001;
    case (mode)
      0: return 1'b1;
      1: return pat[k % 6];
      2: return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // compare this cycle, drive inputs, advance model, move to next cycle
  task automatic cyc(input bit r, input bit go);
    bit e_rd, empty_now, pend_old, od, odr, orun, idle, stop;
    logic [W-1:0] w;
    e_rd = exp_rd();
    chk("valid", 32'(pe_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("pe_instr", pe_instr, q[0]);
    if (prev_stall) chk("stall_hold", pe_instr, prev_instr);
    chk("busy", 32'(busy), 32'(m_run || m_drain));
    chk("done", 32'(done), 32'(m_done));
    chk("err_overrun", 32'(err), 32'(m_err));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    if (e_rd) chk("rd_addr", 32'(addr), 32'(nxt_a));
    if (q.size() + 32'(pend) == 3) chk("no_overflow", 32'(rd_en), 32'd0);
    if (done) n_done++;
    if (pe_valid && r) n_acc++;
    prev_stall = pe_valid && !r;
    prev_instr = pe_instr;
    rdy = r;
    vfu = go;

    empty_now = (q.size() == 0);
    pend_old = pend;
    od = m_done; odr = m_drain; orun = m_run;
    idle = !orun && !odr && !od;
    stop = 0;
    if (q.size() != 0 && r) q.delete(0);
    if (orun && pend_old) begin
      w = mem[pend_a];
      if (is_halt(w)) stop = 1;
      else begin
        q.push_back(w);
        if (pend_a == N - 1) begin
          m_err = 1;
          stop = 1;
        end
      end
    end
    pend = e_rd;
    if (e_rd) begin
      pend_a = nxt_a;
      if (nxt_a == N - 1) last_iss = 1;
      else nxt_a++;
    end
    m_done  = odr && empty_now && !pend_old;
    m_drain = (odr && !(empty_now && !pend_old)) || (orun && stop);
    m_run   = (orun && !stop) || (idle && go);
    if (idle && go) begin
      q.delete();
      nxt_a = 0;
      last_iss = 0;
      m_err = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog(input int mode, input int rp, input int budget);
    int k;
    cyc(rdy_fn(mode, 0), 1'b1);
    k = 1;
    while ((m_run || m_drain || m_done) && k < budget) begin
      cyc(rdy_fn(mode, k), k == rp);
      k++;
    end
    chk("timeout", 32'(k < budget), 32'd1);
    cyc(1'b1, 1'b0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
    mem[0] = 32'h1000_0001;
    mem[1] = 32'h2000_0002;
    mem[2] = 32'h3000_0003;
    mem[3] = 32'hF000_0000;
  endtask

  initial begin
    int a0, d0, hpos;
    model_reset();
    load_basic();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pe_valid), 32'd0);
    chk("rst_instr", pe_instr, 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);

    // basic program, ready held high
    a0 = n_acc; d0 = n_done;
    run_prog(0, -1, 40);
    chk("t1_delivered", 32'(n_acc - a0), 32'd3);
    chk("t1_done_cnt", 32'(n_done - d0), 32'd1);

    // ready toggling 1,0,0,1,0,1
    a0 = n_acc; d0 = n_done;
    run_prog(1, -1, 60);
    chk("t2_delivered", 32'(n_acc - a0), 32'd3);
    chk("t2_done_cnt", 32'(n_done - d0), 32'd1);

    // HALT at address 0
    mem[0] = 32'hF000_0000;
    a0 = n_acc; d0 = n_done;
    run_prog(0, -1, 40);
    chk("t3_delivered", 32'(n_acc - a0), 32'd0);
    chk("t3_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);

    // no HALT anywhere: end of BRAM
    for (int i = 0; i < N; i++) mem[i] = {4'h1, 28'(i)};
    a0 = n_acc; d0 = n_done;
    run_prog(0, -1, 60);
    chk("t4_delivered", 32'(n_acc - a0), 32'd8);
    chk("t4_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t4_err_set", 32'(err), 32'd1);
    load_basic();
    cyc(1'b1, 1'b1);
    chk("t4_err_clear", 32'(err), 32'd0);
    while (m_run || m_drain || m_done) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);

    // reset mid-run with two entries buffered
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("t5_valid_before", 32'(pe_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(pe_valid), 32'd0);
    chk("t5_async_instr", pe_instr, 32'd0);
    chk("t5_async_rd_en", 32'(rd_en), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_addr", 32'(addr), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0 = n_done;
    repeat (6) cyc(1'b1, 1'b0);
    chk("t5_no_done", 32'(n_done - d0), 32'd0);

    // second pulse during RUN is ignored
    a0 = n_acc; d0 = n_done;
    run_prog(0, 2, 40);
    chk("t6_delivered", 32'(n_acc - a0), 32'd3);
    chk("t6_done_cnt", 32'(n_done - d0), 32'd1);
    a0 = n_acc;
    run_prog(2, -1, 80);
    chk("t6_restart", 32'(n_acc - a0), 32'd3);

    // random programs, random ready, occasional stray pulses
    for (int t = 0; t < 25; t++) begin
      hpos = $urandom_range(0, N);
      for (int i = 0; i < N; i++)
        mem[i] = {4'($urandom_range(0, 14)), 28'($urandom)};
      if (hpos < N) mem[hpos] = {4'hF, 28'($urandom)};
      a0 = n_acc; d0 = n_done;
      run_prog(2, $urandom_range(1, 12), 120);
      chk("rnd_delivered", 32'(n_acc - a0), 32'(hpos));
      chk("rnd_done_cnt", 32'(n_done - d0), 32'd1);
      repeat ($urandom_range(0, 3)) cyc(1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
